conv2_window_buf: RTL and testbench
===================================

// Module: conv2_window_buf
// PURPOSE
//  Streaming 5x5 window generator that feeds the conv2 channel calculators.
//  - Input: three pooled conv1 feature maps, raster order, one pixel per channel per accepted cycle.
//  - Output: all 25 taps of each channel's window plus a one-cycle valid_out_buf strobe.
//  - Per channel: one shift register of (FILTER-1)*WIDTH+FILTER entries; taps are read from it.
// PARAMETERS
//  WIDTH      12  feature-map columns
//  HEIGHT     12  feature-map rows
//  DATA_BITS  12  bits per pixel (passed through unmodified)
//  FILTER     5   window edge; tap count = FILTER*FILTER
// PORTS
//  clk            in   1            clock; all logic on posedge
//  rst_n          in   1            reset, synchronous, active-low
//  valid_in       in   1            pixel triple valid this cycle; no backpressure
//  data_in1       in   DATA_BITS    channel 1 pixel
//  data_in2       in   DATA_BITS    channel 2 pixel
//  data_in3       in   DATA_BITS    channel 3 pixel
//  data_out1      out  25*DATA_BITS  ch1 window; tap k=r*5+c at [k*DATA_BITS +: DATA_BITS]
//  data_out2      out  25*DATA_BITS  ch2 window, same layout
//  data_out3      out  25*DATA_BITS  ch3 window, same layout
//  valid_out_buf  out  1            window outputs valid this cycle
// BEHAVIOUR
//  - Reset: col=0, row=0, valid_out_buf=0, all data_out=0. Shift-register contents are don't-care.
//  - Accept, valid_in=1 at posedge:
//    - each channel shifts its new pixel in;
//    - col increments; on col==WIDTH-1 it wraps to 0 and row increments;
//    - on row==HEIGHT-1 and col==WIDTH-1, both wrap to 0; the next frame follows with no gap.
//  - valid_in=0: no shift, counters hold, valid_out_buf=0 next cycle, data_out hold last value.
//  - Window valid when the accepted pixel has row>=FILTER-1 and col>=FILTER-1.
//  - Latency: 1 cycle. data_out* and valid_out_buf are registered at the edge after the accepting edge.
//  - Tap meaning: tap(r,c) = pixel(row-4+r, col-4+c). Tap 0 is the top-left (oldest); tap 24 is the pixel just accepted.
//  - Windows per frame: (HEIGHT-4)*(WIDTH-4) = 64.
//    - No window is emitted while col<4; this covers row wrap and row 0..3 of a new frame.
//    - Stale data from the previous frame never produces a valid window.
//  - Reset asserted mid-frame: counters return to 0 at that edge and valid_out_buf=0 next cycle.
//    The first window after reset needs 53 fresh accepted pixels.
//  - valid_out_buf is a level per window; back-to-back windows give consecutive high cycles.
// CONFIGURATION
//  CONV2_BUF_FRAME_DONE_EN defined:
//    - adds output frame_done (1 bit, reset 0);
//    - frame_done pulses high for 1 cycle, aligned with valid_out_buf for the 64th (last) window of each frame.
//  Macro undefined: no frame_done port; all other behaviour identical.
// TESTING
//  1. Reset, then stream pixel=row*12+col (ch2 +256, ch3 +512), valid_in=1 continuous:
//     -> first valid_out_buf after the 53rd pixel;
//     -> data_out1 tap0=0, tap4=4, tap20=48, tap24=52; ch2 tap24=308; ch3 tap24=564.
//  2. Full frame continuous -> exactly 64 valid_out_buf cycles.
//     Last window: tap24=143, tap0=91. No valid on any col<4 pixel.
//  3. Random valid_in gaps (~30% idle) over a frame:
//     -> same 64 windows in the same order with identical tap values;
//     -> valid_out_buf=0 on every cycle following an idle cycle.
//  4. Two back-to-back frames:
//     -> 128 valid windows in total;
//     -> frame-2 first window tap0 = frame-2 pixel(0,0), no frame-1 data;
//     -> no valid during frame-2 rows 0..3.
//  5. rst_n low for 1 cycle after 70 pixels:
//     -> valid_out_buf=0 and data_out=0 next cycle;
//     -> the next valid appears only after 53 new pixels.
//  6. With CONV2_BUF_FRAME_DONE_EN: frame_done high exactly once per frame, same cycle as the 64th valid_out_buf.

Source files
------------

// File: rtl/conv2_window_buf.sv
`default_nettype none
// ============================================================================
// Module      : conv2_window_buf
// Description : Streaming 5x5 window generator for the conv2 channel
//               calculators. Three raster-ordered feature maps are shifted
//               into per-channel line histories. All 25 taps of every complete
//               window are registered out with a one-cycle valid strobe.
//               Optional feature: define CONV2_BUF_FRAME_DONE_EN to add a
//               frame_done pulse aligned with the last window of each frame.
// Revision    : 1.0 - initial release
// ============================================================================
module conv2_window_buf #(
    parameter int WIDTH     = 12,
    parameter int HEIGHT    = 12,
    parameter int DATA_BITS = 12,
    parameter int FILTER    = 5
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  valid_in,
    input  logic [DATA_BITS-1:0]                  data_in1,
    input  logic [DATA_BITS-1:0]                  data_in2,
    input  logic [DATA_BITS-1:0]                  data_in3,
    output logic [FILTER*FILTER*DATA_BITS-1:0]    data_out1,
    output logic [FILTER*FILTER*DATA_BITS-1:0]    data_out2,
    output logic [FILTER*FILTER*DATA_BITS-1:0]    data_out3,
    output logic                                  valid_out_buf
`ifdef CONV2_BUF_FRAME_DONE_EN
    ,
    output logic                                  frame_done
`endif
);

    localparam int NCH   = 3;
    localparam int TAPS  = FILTER * FILTER;
    localparam int BUS_W = TAPS * DATA_BITS;
    // The full line span is (FILTER-1)*WIDTH+FILTER pixels. The newest one is
    // the pixel being accepted, so only the older entries need storage.
    localparam int DEPTH = (FILTER - 1) * WIDTH + FILTER;
    localparam int HIST  = DEPTH - 1;
    localparam int COL_W = $clog2(WIDTH);
    localparam int ROW_W = $clog2(HEIGHT);

    logic [DATA_BITS-1:0]          pix_in [NCH];
    logic [DATA_BITS-1:0]          hist_q [NCH][HIST];
    logic [NCH-1:0][BUS_W-1:0]     win_d;
    logic [NCH-1:0][BUS_W-1:0]     data_q;
    logic [COL_W-1:0]              col_q, col_d;
    logic [ROW_W-1:0]              row_q, row_d;
    logic                          valid_q;
    logic                          col_last, row_last, win_ok;

    assign pix_in[0] = data_in1;
    assign pix_in[1] = data_in2;
    assign pix_in[2] = data_in3;

    // Line history: hist_q[ch][0] is the previously accepted pixel, older ones follow.
    always_ff @(posedge clk) begin
        if (valid_in) begin
            for (int ch = 0; ch < NCH; ch++) begin
                hist_q[ch][0] <= pix_in[ch];
                for (int i = 1; i < HIST; i++) begin
                    hist_q[ch][i] <= hist_q[ch][i-1];
                end
            end
        end
    end

    // Tap (r,c) is the pixel accepted AGE pixels before the current one.
    generate
        for (genvar ch = 0; ch < NCH; ch++) begin : g_ch
            for (genvar k = 0; k < TAPS; k++) begin : g_tap
                localparam int AGE = (FILTER - 1 - k / FILTER) * WIDTH
                                   + (FILTER - 1 - k % FILTER);
                if (AGE == 0) begin : g_new
                    assign win_d[ch][k*DATA_BITS +: DATA_BITS] = pix_in[ch];
                end else begin : g_old
                    assign win_d[ch][k*DATA_BITS +: DATA_BITS] = hist_q[ch][AGE-1];
                end
            end
        end
    endgenerate

    assign col_last = (col_q == COL_W'(WIDTH - 1));
    assign row_last = (row_q == ROW_W'(HEIGHT - 1));
    // A window is complete only once FILTER-1 rows and columns precede the pixel,
    // so row wraps and the first rows of a frame never emit stale windows.
    assign win_ok   = valid_in && (col_q >= COL_W'(FILTER - 1))
                               && (row_q >= ROW_W'(FILTER - 1));

    // Raster position of the pixel presented on the inputs.
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (valid_in) begin
            if (col_last) begin
                col_d = '0;
                row_d = row_last ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    // Counters and registered window outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col_q   <= '0;
            row_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            col_q   <= col_d;
            row_q   <= row_d;
            valid_q <= win_ok;
            if (valid_in) begin
                data_q <= win_d;
            end
        end
    end

    assign data_out1     = data_q[0];
    assign data_out2     = data_q[1];
    assign data_out3     = data_q[2];
    assign valid_out_buf = valid_q;

`ifdef CONV2_BUF_FRAME_DONE_EN
    logic frame_done_q;

    // Last window of the frame is the one taken at the bottom-right pixel.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= win_ok && col_last && row_last;
        end
    end

    assign frame_done = frame_done_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_conv2_window_buf.sv
`default_nettype none
// ============================================================================
// Module      : tb_conv2_window_buf
// Description : Directed self-checking bench for conv2_window_buf. Streams
//               row*12+col pixel frames (ch2 +256, ch3 +512, plus a frame
//               offset) continuously, with idle gaps, back to back, and
//               across a mid-frame reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_conv2_window_buf;

    localparam int W    = 12;
    localparam int H    = 12;
    localparam int DB   = 12;
    localparam int F    = 5;
    localparam int TAPS = F * F;
    localparam int BUS  = TAPS * DB;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           valid_in;
    logic [DB-1:0]  data_in1, data_in2, data_in3;
    logic [BUS-1:0] data_out1, data_out2, data_out3;
    logic           valid_out_buf;
`ifdef CONV2_BUF_FRAME_DONE_EN
    logic           frame_done;
    int             fd_count = 0;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    int            nwin, first_at, total_win;
    logic [DB-1:0] f_t0, f_t4, f_t20, f_t24, f2_t24, f3_t24, l_t0, l_t24;

    always #5 clk = ~clk;

    conv2_window_buf dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .valid_in      (valid_in),
        .data_in1      (data_in1),
        .data_in2      (data_in2),
        .data_in3      (data_in3),
        .data_out1     (data_out1),
        .data_out2     (data_out2),
        .data_out3     (data_out3),
        .valid_out_buf (valid_out_buf)
`ifdef CONV2_BUF_FRAME_DONE_EN
        ,
        .frame_done    (frame_done)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic logic [DB-1:0] tap_of(input logic [BUS-1:0] bus, input int k);
        return bus[k*DB +: DB];
    endfunction

    // Drive one cycle, then sample just after the edge.
    task automatic push(input logic v, input int r, input int c, input int off);
        valid_in = v;
        data_in1 = DB'(r * W + c + off);
        data_in2 = DB'(r * W + c + off + 256);
        data_in3 = DB'(r * W + c + off + 512);
        @(posedge clk);
        #1;
    endtask

    // Stream up to npix pixels of one frame; optional idle cycles before pixels.
    task automatic run_frame(input int off, input int npix, input int idle_pct);
        int   acc;
        logic expv;
        acc      = 0;
        nwin     = 0;
        first_at = 0;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                if (acc < npix) begin
                    if (idle_pct > 0 && $urandom_range(99) < idle_pct) begin
                        push(1'b0, r, c, off);
                        check("valid_after_idle", {31'b0, valid_out_buf}, 0);
`ifdef CONV2_BUF_FRAME_DONE_EN
                        check("frame_done_idle", {31'b0, frame_done}, 0);
`endif
                    end
                    push(1'b1, r, c, off);
                    acc++;
                    expv = (r >= F - 1) && (c >= F - 1);
                    check("valid", {31'b0, valid_out_buf}, {31'b0, expv});
`ifdef CONV2_BUF_FRAME_DONE_EN
                    check("frame_done", {31'b0, frame_done},
                          {31'b0, expv && r == H - 1 && c == W - 1});
                    if (frame_done) fd_count++;
`endif
                    if (expv && valid_out_buf) begin
                        nwin++;
                        if (nwin == 1) begin
                            first_at = acc;
                            f_t0   = tap_of(data_out1, 0);
                            f_t4   = tap_of(data_out1, 4);
                            f_t20  = tap_of(data_out1, 20);
                            f_t24  = tap_of(data_out1, 24);
                            f2_t24 = tap_of(data_out2, 24);
                            f3_t24 = tap_of(data_out3, 24);
                        end
                        l_t0  = tap_of(data_out1, 0);
                        l_t24 = tap_of(data_out1, 24);
                        for (int k = 0; k < TAPS; k++) begin
                            check("tap_ch1", {20'b0, tap_of(data_out1, k)},
                                  32'((r - 4 + k / F) * W + (c - 4 + k % F) + off));
                        end
                        check("tap24_ch2", {20'b0, tap_of(data_out2, 24)}, 32'(r * W + c + off + 256));
                        check("tap24_ch3", {20'b0, tap_of(data_out3, 24)}, 32'(r * W + c + off + 512));
                    end
                end
            end
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        valid_in = 1'b0;
        data_in1 = '0;
        data_in2 = '0;
        data_in3 = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", {31'b0, valid_out_buf}, 0);
        check("rst_data", {31'b0, |{data_out1, data_out2, data_out3}}, 0);
`ifdef CONV2_BUF_FRAME_DONE_EN
        check("rst_frame_done", {31'b0, frame_done}, 0);
`endif
        rst_n = 1'b1;

        // First frame, continuous.
        run_frame(0, W * H, 0);
        check("f1_first_at", first_at, 53);
        check("f1_tap0", {20'b0, f_t0}, 0);
        check("f1_tap4", {20'b0, f_t4}, 4);
        check("f1_tap20", {20'b0, f_t20}, 48);
        check("f1_tap24", {20'b0, f_t24}, 52);
        check("f1_ch2_tap24", {20'b0, f2_t24}, 308);
        check("f1_ch3_tap24", {20'b0, f3_t24}, 564);
        check("f1_windows", nwin, 64);
        check("f1_last_tap0", {20'b0, l_t0}, 91);
        check("f1_last_tap24", {20'b0, l_t24}, 143);
        total_win = nwin;

        // Second frame immediately after, distinct pixel values.
        run_frame(2000, W * H, 0);
        check("f2_windows", nwin, 64);
        check("f2_first_at", first_at, 53);
        check("f2_tap0", {20'b0, f_t0}, 2000);
        check("f2_tap24", {20'b0, f_t24}, 2052);
        total_win += nwin;
        check("two_frame_windows", total_win, 128);

        // Frame with roughly 30% idle cycles.
        run_frame(0, W * H, 30);
        check("gap_windows", nwin, 64);
        check("gap_first_tap24", {20'b0, f_t24}, 52);
        check("gap_last_tap0", {20'b0, l_t0}, 91);
        check("gap_last_tap24", {20'b0, l_t24}, 143);

        // 70 pixels, then reset mid-frame.
        run_frame(0, 70, 0);
        check("partial_windows", nwin, 14);
        rst_n    = 1'b0;
        valid_in = 1'b1;
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        valid_in = 1'b0;
        check("midrst_valid", {31'b0, valid_out_buf}, 0);
        check("midrst_data", {31'b0, |{data_out1, data_out2, data_out3}}, 0);

        run_frame(3000, W * H, 0);
        check("post_rst_first_at", first_at, 53);
        check("post_rst_tap0", {20'b0, f_t0}, 3000);
        check("post_rst_windows", nwin, 64);
`ifdef CONV2_BUF_FRAME_DONE_EN
        check("frame_done_count", fd_count, 4);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
